// File: rtl/game_pkg.sv
// Shared game constants: FSM state codes, digit count, segment patterns and the
// empty-digit code also used by keypad capture.
package game_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShow   = 2'd1;
  localparam logic [1:0] StGap    = 2'd2;
  localparam logic [1:0] StFinish = 2'd3;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [6:0] SEG_DASH    = 7'b0111111;
  localparam logic [3:0] EMPTY_DIGIT = 4'hF;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Nibble to active-low {g,f,e,d,c,b,a} segment map; 10-14 render as a dash and
// EMPTY_DIGIT renders blank.
module seg7_encoder
  import game_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (digit_i)
      4'd0:        seg_o = 7'b1000000;
      4'd1:        seg_o = 7'b1111001;
      4'd2:        seg_o = 7'b0100100;
      4'd3:        seg_o = 7'b0110000;
      4'd4:        seg_o = 7'b0011001;
      4'd5:        seg_o = 7'b0010010;
      4'd6:        seg_o = 7'b0000010;
      4'd7:        seg_o = 7'b1111000;
      4'd8:        seg_o = 7'b0000000;
      4'd9:        seg_o = 7'b0010000;
      EMPTY_DIGIT: seg_o = SEG_BLANK;
      default:     seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sequence_display.sv
// Plays a latched 4-digit pattern on the seven-segment display, one digit per slot.
// Define SEQ_DISPLAY_HISTORY_EN to keep earlier digits lit via anode multiplexing.
module sequence_display
  import game_pkg::*;
#(
  parameter int unsigned SHOW_TICKS    = 50000000,
  parameter int unsigned GAP_TICKS     = 12500000,
  parameter int unsigned REFRESH_TICKS = 100000
) (
  input  logic        masterClk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] pattern_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [6:0]  seg_o,
  output logic [3:0]  an_o
);

  localparam int unsigned CntW = $clog2(max3(SHOW_TICKS, GAP_TICKS, REFRESH_TICKS)) + 1;
  localparam logic [CntW-1:0] ShowLast = CntW'(SHOW_TICKS - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_TICKS - 1);
  localparam logic [1:0]      LastIdx  = 2'(NUM_DIGITS - 1);

  logic [1:0]      state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     pat_q, pat_d;
  logic            busy_d, done_d;
  logic [6:0]      seg_d, seg_enc;
  logic [3:0]      an_d, nib;
  logic [1:0]      sel_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StShow;
          idx_d   = 2'd0;
          cnt_d   = '0;
          pat_d   = pattern_i;
        end
      end
      StShow: begin
        if (cnt_q == ShowLast) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StFinish;
          end else begin
            state_d = StShow;
            idx_d   = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    nib = pat_d[15:12];
    case (sel_d)
      2'd0:    nib = pat_d[15:12];
      2'd1:    nib = pat_d[11:8];
      2'd2:    nib = pat_d[7:4];
      default: nib = pat_d[3:0];
    endcase
  end

  seg7_encoder u_enc (
    .digit_i(nib),
    .seg_o  (seg_enc)
  );

`ifdef SEQ_DISPLAY_HISTORY_EN
  localparam logic [CntW-1:0] RefLast = CntW'(REFRESH_TICKS - 1);

  logic [CntW-1:0] ref_q, ref_d;
  logic [1:0]      slot_q, slot_d;
  logic [2:0]      nlit;

  // Slots 0..idx are lit in SHOW; the current slot drops out during GAP.
  always_comb begin
    nlit = 3'd0;
    if (state_d == StShow) begin
      nlit = {1'b0, idx_d} + 3'd1;
    end else if (state_d == StGap) begin
      nlit = {1'b0, idx_d};
    end
    ref_d  = ref_q + CntW'(1);
    slot_d = slot_q;
    if (ref_q == RefLast) begin
      ref_d  = '0;
      slot_d = (({1'b0, slot_q} + 3'd1) >= nlit) ? 2'd0 : slot_q + 2'd1;
    end else if ({1'b0, slot_q} >= nlit) begin
      slot_d = 2'd0;
    end
    sel_d = slot_d;
  end

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 4'b1111;
    if ({1'b0, slot_d} < nlit) begin
      seg_d = seg_enc;
      an_d  = ~(4'b1000 >> slot_d);
    end
  end

  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) begin
      ref_q  <= '0;
      slot_q <= 2'd0;
    end else begin
      ref_q  <= ref_d;
      slot_q <= slot_d;
    end
  end
`else
  always_comb begin
    sel_d = idx_d;
    seg_d = SEG_BLANK;
    an_d  = 4'b1111;
    if (state_d == StShow) begin
      seg_d = seg_enc;
      an_d  = ~(4'b1000 >> idx_d);
    end
  end
`endif

  // Outputs are registered from next-state so they line up with the state they describe.
  assign busy_d = (state_d == StShow) || (state_d == StGap);
  assign done_d = (state_d == StFinish);

  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      pat_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      seg_o   <= SEG_BLANK;
      an_o    <= 4'b1111;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
      seg_o   <= seg_d;
      an_o    <= an_d;
    end
  end

endmodule

// File: tb/tb_sequence_display.sv
// Directed bench for sequence_display with SHOW_TICKS=4, GAP_TICKS=2, REFRESH_TICKS=2.
module tb_sequence_display;

  localparam int unsigned ShowT  = 4;
  localparam int unsigned GapT   = 2;
  localparam int unsigned RefT   = 2;
  localparam int unsigned SlotT  = ShowT + GapT;
  localparam int          SeqLen = 4 * SlotT;

  logic        masterClk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] pattern_i;
  logic        busy_o;
  logic        done_o;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;

  int errors = 0;
  int checks = 0;

  always #5 masterClk = ~masterClk;

  sequence_display #(
    .SHOW_TICKS   (ShowT),
    .GAP_TICKS    (GapT),
    .REFRESH_TICKS(RefT)
  ) dut (
    .masterClk(masterClk),
    .rst      (rst),
    .start_i  (start_i),
    .pattern_i(pattern_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .seg_o    (seg_o),
    .an_o     (an_o)
  );

  function automatic logic [6:0] enc_ref(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      4'd15:   return 7'b1111111;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected {an, seg} in cycle n after the start edge (single-digit mode).
  function automatic logic [10:0] exp_disp(input logic [15:0] pat, input int n);
    int d;
    int off;
    logic [3:0] nib;
    if (n < 1 || n > SeqLen) return {4'b1111, 7'b1111111};
    d   = (n - 1) / SlotT;
    off = (n - 1) % SlotT;
    if (off >= ShowT) return {4'b1111, 7'b1111111};
    nib = pat[15 - 4*d -: 4];
    return {4'b1111 ^ (4'b1000 >> d), enc_ref(nib)};
  endfunction

  task automatic tick();
    @(posedge masterClk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    pattern_i = 16'h0000;
    #1;
    checks++;
    if ({busy_o, done_o, an_o, seg_o} !== {2'b00, 4'b1111, 7'b1111111}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b an=%b seg=%b, want 0 0 1111 1111111",
               busy_o, done_o, an_o, seg_o);
    end
    tick();
    tick();
    #3 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({busy_o, done_o, an_o, seg_o} !== {2'b00, 4'b1111, 7'b1111111}) begin
        errors++;
        $display("FAIL idle_%0d: got busy=%b done=%b an=%b seg=%b, want 0 0 1111 1111111",
                 i, busy_o, done_o, an_o, seg_o);
      end
    end
  endtask

  // Starts pat, then walks every cycle to one past done. Ends idle at a sample point.
  task automatic test_sequence(input logic [15:0] pat, input logic [15:0] later_pat,
                               input string name);
    logic [10:0] e;
    int dones;
    dones = 0;
    start_i = 1'b1;
    pattern_i = pat;
    tick();
    start_i = 1'b0;
    pattern_i = later_pat;
    for (int n = 1; n <= SeqLen + 2; n++) begin
      e = exp_disp(pat, n);
      if (done_o === 1'b1) dones++;
`ifndef SEQ_DISPLAY_HISTORY_EN
      checks++;
      if ({an_o, seg_o} !== e) begin
        errors++;
        $display("FAIL %s_disp_c%0d: got an=%b seg=%b, want an=%b seg=%b",
                 name, n, an_o, seg_o, e[10:7], e[6:0]);
      end
`endif
      checks++;
      if (busy_o !== (n <= SeqLen)) begin
        errors++;
        $display("FAIL %s_busy_c%0d: got %b, want %b", name, n, busy_o, n <= SeqLen);
      end
      checks++;
      if (done_o !== (n == SeqLen + 1)) begin
        errors++;
        $display("FAIL %s_done_c%0d: got %b, want %b", name, n, done_o, n == SeqLen + 1);
      end
      tick();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, want 1", name, dones);
    end
  endtask

  task automatic test_start_ignored();
    logic [10:0] e;
    int dones;
    dones = 0;
    start_i = 1'b1;
    pattern_i = 16'h1234;
    tick();
    start_i = 1'b0;
    pattern_i = 16'h5555;
    for (int n = 1; n <= SeqLen + 8; n++) begin
      e = exp_disp(16'h1234, n);
      if (done_o === 1'b1) dones++;
`ifndef SEQ_DISPLAY_HISTORY_EN
      checks++;
      if ({an_o, seg_o} !== e) begin
        errors++;
        $display("FAIL ignore_disp_c%0d: got an=%b seg=%b, want an=%b seg=%b",
                 n, an_o, seg_o, e[10:7], e[6:0]);
      end
`endif
      checks++;
      if (busy_o !== (n <= SeqLen)) begin
        errors++;
        $display("FAIL ignore_busy_c%0d: got %b, want %b", n, busy_o, n <= SeqLen);
      end
      start_i = (n == 3 || n == 10);
      tick();
    end
    start_i = 1'b0;
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d, want 1", dones);
    end
  endtask

  // start held across FINISH is taken on the first IDLE cycle.
  task automatic test_hold_start();
    start_i = 1'b1;
    pattern_i = 16'h1234;
    tick();
    for (int n = 1; n <= SeqLen + 1; n++) tick();
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      errors++;
      $display("FAIL hold_idle_cycle: got busy=%b done=%b, want 0 0", busy_o, done_o);
    end
    tick();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_restart_busy: got %b, want 1", busy_o);
    end
`ifndef SEQ_DISPLAY_HISTORY_EN
    checks++;
    if ({an_o, seg_o} !== {4'b0111, 7'b1111001}) begin
      errors++;
      $display("FAIL hold_restart_disp: got an=%b seg=%b, want 0111 1111001", an_o, seg_o);
    end
`endif
    for (int n = 2; n <= SeqLen + 1; n++) tick();
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_restart_done: got %b, want 1", done_o);
    end
    tick();
  endtask

  task automatic test_async_reset(input int at_cycle);
    start_i = 1'b1;
    pattern_i = 16'h1234;
    tick();
    start_i = 1'b0;
    for (int n = 1; n < at_cycle; n++) tick();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_busy_c%0d: got %b, want 1", at_cycle, busy_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy_o, done_o, an_o, seg_o} !== {2'b00, 4'b1111, 7'b1111111}) begin
      errors++;
      $display("FAIL areset_blank_c%0d: got busy=%b done=%b an=%b seg=%b, want 0 0 1111 1111111",
               at_cycle, busy_o, done_o, an_o, seg_o);
    end
    #1 rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy_o, done_o, an_o} !== {2'b00, 4'b1111}) begin
      errors++;
      $display("FAIL areset_stays_idle_c%0d: got busy=%b done=%b an=%b, want 0 0 1111",
               at_cycle, busy_o, done_o, an_o);
    end
  endtask

`ifdef SEQ_DISPLAY_HISTORY_EN
  task automatic test_history();
    int seen0;
    int seen1;
    seen0 = 0;
    seen1 = 0;
    start_i = 1'b1;
    pattern_i = 16'h1234;
    tick();
    start_i = 1'b0;
    for (int n = 1; n <= SeqLen + 1; n++) begin
      if (n >= SlotT + 1 && n <= SlotT + ShowT) begin
        if ({an_o, seg_o} === {4'b0111, 7'b1111001}) seen0++;
        else if ({an_o, seg_o} === {4'b1011, 7'b0100100}) seen1++;
        else begin
          checks++;
          errors++;
          $display("FAIL hist_slot_c%0d: got an=%b seg=%b, want 0111/1111001 or 1011/0100100",
                   n, an_o, seg_o);
        end
      end
      tick();
    end
    tick();
    checks++;
    if (seen0 != 2 || seen1 != 2) begin
      errors++;
      $display("FAIL hist_alternation: got %0d/%0d cycles on slots 0/1, want 2/2", seen0, seen1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence(16'h1234, 16'hFFFF, "p1234");
    test_sequence(16'h9FA0, 16'h1111, "p9FA0");
    test_start_ignored();
    test_hold_start();
    test_async_reset(6);
    test_async_reset(3);
    test_sequence(16'h8765, 16'h0000, "after_reset");
`ifdef SEQ_DISPLAY_HISTORY_EN
    test_history();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
